// File: rtl/dmem_pkg.sv
// Shared defaults and the write-buffer entry layout for the M-stage
// data-memory responder.
package dmem_pkg;

   localparam int DMEM_ADDR_W   = 8;
   localparam int DMEM_WB_DEPTH = 4;

   typedef struct packed {
      logic [DMEM_ADDR_W-1:0] index;
      logic [31:0]            data;
   } wb_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-store FIFO: circular storage, pointers, occupancy and a
// newest-match lookup used to forward buffered stores to loads.
module wbuf_fifo
   import dmem_pkg::*;
#(
   parameter int  DEPTH = DMEM_WB_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic                   i_drain,
   input  wb_entry_t              i_entry,
   input  logic [DMEM_ADDR_W-1:0] i_idx,
   output wb_entry_t              o_head,
   output logic [CW-1:0]          o_count,
   output logic                   o_full,
   output logic                   o_empty,
   output logic                   o_hit,
   output logic [31:0]            o_data
);

   wb_entry_t       r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   w_slot;

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_drain) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_drain})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Walk oldest to newest so the last match (newest store) wins.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_slot = r_rd_ptr;
      for (int k = 0; k < DEPTH; k++) begin
         w_slot = r_rd_ptr + PW'(k);
         if (CW'(k) < r_count && r_mem[w_slot].index == i_idx) begin
            o_hit  = 1'b1;
            o_data = r_mem[w_slot].data;
         end
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/dmem_wbuf_responder.sv
// Word data memory for the M stage: zero-latency loads, posted stores
// through a small write buffer that drains to RAM one entry per cycle.
module dmem_wbuf_responder
   import dmem_pkg::*;
#(
   parameter int  ADDR_W   = DMEM_ADDR_W,
   parameter int  WB_DEPTH = DMEM_WB_DEPTH,
   localparam int CW       = $clog2(WB_DEPTH) + 1
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          MemWrite,
   input  logic [31:0]   ALUResult,
   input  logic [31:0]   WriteData,
   output logic [31:0]   ReadData,
   output logic [CW-1:0] wb_count,
   output logic          wb_empty,
   output logic          err_oor
);

   logic [31:0]       r_ram [2**ADDR_W];
   logic              r_err_oor;
   logic [ADDR_W-1:0] w_idx;
   logic              w_in_range;
   logic              w_push;
   logic              w_drain;
   logic              w_full;
   logic              w_empty;
   logic              w_hit;
   logic [31:0]       w_fwd;
   wb_entry_t         w_entry;
   wb_entry_t         w_head;
   logic              w_unused_lo;

   assign w_idx       = ALUResult[ADDR_W+1:2];
   assign w_in_range  = (ALUResult[31:ADDR_W+2] == '0);
   assign w_unused_lo = ^ALUResult[1:0];
   assign w_entry     = '{index: w_idx, data: WriteData};

   // Drain on any non-store cycle; a full buffer drains under a store
   // so the core never has to stall.
   assign w_push  = MemWrite && w_in_range;
   assign w_drain = !w_empty && (!MemWrite || w_full);

   wbuf_fifo #(
      .DEPTH (WB_DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (Reset),
      .i_push  (w_push),
      .i_drain (w_drain),
      .i_entry (w_entry),
      .i_idx   (w_idx),
      .o_head  (w_head),
      .o_count (wb_count),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_hit   (w_hit),
      .o_data  (w_fwd)
   );

   always_ff @(posedge CLK) begin
      if (w_drain) r_ram[w_head.index] <= w_head.data;
   end

   // Every cycle presents an address, so any out-of-range one flags.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)           r_err_oor <= 1'b0;
      else if (!w_in_range) r_err_oor <= 1'b1;
   end

   always_comb begin
      ReadData = r_ram[w_idx];
      if (!w_in_range) ReadData = '0;
      else if (w_hit)  ReadData = w_fwd;
   end

   assign wb_empty = w_empty;
   assign err_oor  = r_err_oor;

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Directed scoreboard bench for dmem_wbuf_responder.
module tb_dmem_wbuf_responder;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [2:0]  wb_count;
   logic        wb_empty;
   logic        err_oor;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] m_mem [int];
   int          m_count = 0;
   logic        m_err   = 1'b0;

   dmem_wbuf_responder dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .wb_count  (wb_count),
      .wb_empty  (wb_empty),
      .err_oor   (err_oor)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"}, 32'(wb_count), 32'(m_count));
      check({tag, ".empty"}, {31'b0, wb_empty}, 32'(m_count == 0));
      check({tag, ".err"},   {31'b0, err_oor},  {31'b0, m_err});
   endtask

   task automatic cyc(input logic mw, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
      logic inr;
      logic push;
      logic drain;
      int   idx;
      @(negedge CLK);
      MemWrite  = mw;
      ALUResult = a;
      WriteData = d;
      #1;
      check_state(tag);
      inr = (a[31:10] == '0);
      idx = int'(a[9:2]);
      if (!inr)                  exp_q.push_back(32'h0);
      else if (m_mem.exists(idx)) exp_q.push_back(m_mem[idx]);
      if (exp_q.size() != 0) check({tag, ".rd"}, ReadData, exp_q.pop_front());
      push  = mw && inr;
      drain = (m_count != 0) && (!mw || m_count == 4);
      m_count = m_count + int'(push) - int'(drain);
      if (push) m_mem[idx] = d;
      if (!inr) m_err = 1'b1;
   endtask

   initial begin
      Reset     = 1'b0;
      MemWrite  = 1'b0;
      ALUResult = '0;
      WriteData = '0;
      #2;
      check_state("por");
      @(negedge CLK);
      Reset = 1'b1;

      // Async reset mid-burst discards buffered stores
      cyc(1'b1, 32'h40, 32'h1111_1111, "t1s0");
      cyc(1'b1, 32'h44, 32'h2222_2222, "t1s1");
      cyc(1'b1, 32'h48, 32'h3333_3333, "t1s2");
      @(posedge CLK);
      #1;
      check("t1.pre_count", 32'(wb_count), 32'd3);
      #1;
      Reset = 1'b0;
      #1;
      m_count = 0;
      m_mem.delete();
      check_state("t1.rst");
      @(negedge CLK);
      Reset    = 1'b1;
      MemWrite = 1'b0;

      // Store then forwarded load, then load from RAM
      cyc(1'b1, 32'h10, 32'hDEAD_BEEF, "t2st");
      cyc(1'b0, 32'h10, 32'h0, "t2fwd");
      cyc(1'b0, 32'h10, 32'h0, "t2ram");

      // Same-index stores: newest wins, both in buffer and RAM
      cyc(1'b1, 32'h20, 32'h1, "t3s0");
      cyc(1'b1, 32'h20, 32'h2, "t3s1");
      cyc(1'b0, 32'h20, 32'h0, "t3fwd");
      cyc(1'b0, 32'h20, 32'h0, "t3d");
      cyc(1'b0, 32'h20, 32'h0, "t3ram");

      // Six stores overflow-free through a 4-deep buffer, wrap pointers
      for (int i = 0; i < 6; i++)
         cyc(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), "t4st");
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 32'(i * 4), 32'h0, "t4drn");
      for (int i = 0; i < 6; i++)
         cyc(1'b0, 32'(i * 4), 32'h0, "t4rd");

      // Out-of-range store dropped, load returns 0, RAM[0] untouched
      cyc(1'b1, 32'h400, 32'h1234_5678, "t5st");
      cyc(1'b0, 32'h400, 32'h0, "t5ld");
      cyc(1'b0, 32'h000, 32'h0, "t5ram");
      check("t5.ram0", ReadData, 32'hA000_0000);

      // Byte offset ignored when forwarding
      cyc(1'b1, 32'h10, 32'h55, "t6st");
      cyc(1'b0, 32'h13, 32'h0, "t6fwd");
      cyc(1'b0, 32'h0, 32'h0, "t6idle");
      cyc(1'b0, 32'h10, 32'h0, "t6ram");

      // Reset clears the sticky error flag
      #1;
      Reset = 1'b0;
      #1;
      m_count = 0;
      m_err   = 1'b0;
      check_state("fin.rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
